uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller for the UART receiver. It enables and disables the receiver, buffers each received character in a first-word-fall-through FIFO, and flags overrun. It also raises an idle-line timeout so the consumer can flush short messages without polling. It sits between the receiver (`rx_done`/`dout`) and the bus-side consumer.

## Interface
- `dbits`, 8, character width; must match the receiver.
- `abits`, 4, FIFO address width; depth = 2^abits (16).
- `tbits`, 16, idle-timeout counter width.
- `timeout_ticks`, 640, idle limit in baud-sample ticks (4 characters at 16x sampling); legal range 2..2^tbits-1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  baud-sample strobe, one `clk` wide; the same strobe that drives the receiver.
- `enable`  in  1  receive enable, level.
- `rx_done`  in  1  one-cycle strobe from the receiver; the character is valid on `rx_data`.
- `rx_data`  in  dbits  received character.
- `rx_rst`  out  1  drives the receiver's reset; 1 whenever the controller is not in RUN.
- `rd_en`  in  1  pop request from the consumer.
- `rd_data`  out  dbits  FIFO head (FWFT).
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  abits+1  FIFO occupancy, 0..2^abits.
- `flush`  in  1  synchronous FIFO clear.
- `overrun`  out  1  sticky: a character was dropped because the FIFO was full.
- `clr_err`  in  1  clears `overrun`.
- `idle_timeout`  out  1  one-cycle pulse: the line has been idle with data still buffered.

## Operation
- States: OFF, RUN.
  - OFF -> RUN when `enable`=1.
  - RUN -> OFF when `enable`=0.
  - Transitions are registered, so `rx_rst` follows `enable` with 1 cycle of latency.
- OFF:
  - `rx_rst`=1 and FIFO writes are blocked; any `rx_done` is ignored.
  - Reads are still allowed, so the consumer can drain.
  - The timeout counter is held at 0 and disarmed.
- RUN:
  - `rx_rst`=0.
  - Leaving RUN mid-frame discards the partial character; nothing is written.
- Write: `rx_done`=1 in RUN with `full`=0 writes `rx_data` at `wr_ptr`. `wr_ptr` increments modulo 2^abits.
- Read: `rd_en`=1 with `empty`=0 increments `rd_ptr` modulo 2^abits. `rd_en` while `empty` is ignored.
- Occupancy:
  - `count` is +1 on a write only, -1 on a read only, and unchanged on simultaneous write and read.
  - `empty` = (`count`==0); `full` = (`count`==2^abits).
- Full FIFO:
  - Write with a simultaneous read: the write is accepted, `count` stays 2^abits, and `overrun` is not set.
  - Write without a read: the character is dropped and `overrun` is set.
- Overrun priority: if a set and `clr_err` occur in the same cycle, the set wins.
- Flush: `flush`=1 zeroes both pointers and `count` and overrides any write or read in that cycle. `overrun` is unaffected.
- Idle timeout (RUN only):
  - The counter increments on `tick` and resets to 0 on an accepted or dropped `rx_done`.
  - Each `rx_done` arms the detector.
  - When the counter equals `timeout_ticks`-1 on a `tick`, the detector is armed and `empty`=0: `idle_timeout` pulses for 1 cycle and the detector disarms. The counter saturates rather than wrapping.
  - If `empty`=1 at expiry, the detector disarms with no pulse.
- `rd_data` = mem[`rd_ptr`] (combinational read of a registered array). It is valid only while `empty`=0. Memory is not reset.

## Timing
- Reset values: state OFF, `rx_rst`=1, `empty`=1, `full`=0, `count`=0, `overrun`=0, `idle_timeout`=0, pointers 0, counter 0, detector disarmed.
- `rx_done` at edge N: at N+1, `count` has incremented, `empty`=0 and `rd_data` shows the character (FWFT head when the FIFO was empty).
- `rd_en` at edge N: at N+1, `rd_data` shows the next entry and `count` has decremented.
- `overrun` rises 1 cycle after the dropped `rx_done`.
- `idle_timeout` is registered, 1 cycle after the qualifying `tick`.
- Asserting `rst` mid-operation immediately forces all reset values, including `rx_rst`=1.

## Test plan
- Reset, `enable`=1: `rx_rst` drops 1 cycle later. Push 0x55, 0xA3 → `count`=2, `rd_data`=0x55; `rd_en` → `rd_data`=0xA3, `count`=1.
- Push 16 characters 0x00..0x0F → `full`=1. Push 0xEE without a read → `overrun`=1 and 0xEE absent. Push 0xEF with `rd_en` → accepted, `count`=16, last entry 0xEF.
- Same cycle as an overrun set, assert `clr_err` → `overrun` stays 1. A lone `clr_err` next cycle → 0.
- Push 1 character, then 639 `tick`s with no `rx_done` → exactly one `idle_timeout` pulse. A further 1000 ticks produce no pulse. With the FIFO empty at expiry there is no pulse.
- `enable`=0 with 3 entries buffered → `rx_rst`=1, `rx_done` ignored, and 3 reads return the data. `flush` simultaneous with `rx_done` in RUN → `count`=0.
- Assert `rst` with 5 entries and `overrun`=1 → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller, the receiver strobes and the bus-side consumer.
// The controller connects through the slave modport; the driving side uses master.
interface uart_rx_ctrl_if #(
  parameter int dbits = 8,
  parameter int abits = 4
);
  logic             tick;
  logic             enable;
  logic             rx_done;
  logic [dbits-1:0] rx_data;
  logic             rx_rst;
  logic             rd_en;
  logic [dbits-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [abits:0]   count;
  logic             flush;
  logic             overrun;
  logic             clr_err;
  logic             idle_timeout;

  modport master (
    output tick, enable, rx_done, rx_data, rd_en, flush, clr_err,
    input  rx_rst, rd_data, empty, full, count, overrun, idle_timeout
  );

  modport slave (
    input  tick, enable, rx_done, rx_data, rd_en, flush, clr_err,
    output rx_rst, rd_data, empty, full, count, overrun, idle_timeout
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: OFF/RUN enable FSM, FWFT character FIFO with sticky overrun,
// and an idle-line timeout that pulses once when buffered data has sat unread.
//
// state | meaning
// OFF   | receiver held in reset, writes blocked, timeout disarmed
// RUN   | receiver running, characters written into the FIFO
module uart_rx_ctrl #(
  parameter int dbits         = 8,
  parameter int abits         = 4,
  parameter int tbits         = 16,
  parameter int timeout_ticks = 640
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_rx_ctrl_if.slave  bus_if
);
  localparam int             depth    = 1 << abits;
  localparam logic [abits:0] full_cnt = (abits+1)'(depth);
  localparam logic [tbits-1:0] tc_last = tbits'(timeout_ticks - 1);
  localparam logic [tbits-1:0] tc_fire = tbits'(timeout_ticks - 2);

  typedef enum logic {OFF, RUN} state_t;

  state_t           state_q, state_d;
  logic [abits-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [abits:0]   count_q, count_d;
  logic             overrun_q, overrun_d;
  logic [tbits-1:0] tmr_q, tmr_d;
  logic             armed_q, armed_d;
  logic             idle_q, idle_d;
  logic [dbits-1:0] mem [depth];

  logic run, is_empty, is_full, rd_ok, wr_ok, drop;

  assign run      = (state_q == RUN);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == full_cnt);
  assign rd_ok    = bus_if.rd_en & ~is_empty;
  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  assign wr_ok    = run & bus_if.rx_done & (~is_full | bus_if.rd_en);
  assign drop     = run & bus_if.rx_done & is_full & ~bus_if.rd_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= OFF;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      tmr_q     <= '0;
      armed_q   <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      tmr_q     <= tmr_d;
      armed_q   <= armed_d;
      idle_q    <= idle_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok && !bus_if.flush) mem[wr_ptr_q] <= bus_if.rx_data;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    tmr_d     = tmr_q;
    armed_d   = armed_q;
    idle_d    = 1'b0;

    if (state_q == OFF) begin
      if (bus_if.enable) state_d = RUN;
    end else begin
      if (!bus_if.enable) state_d = OFF;
    end

    if (bus_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + abits'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + abits'(1);
      if (wr_ok && !rd_ok)      count_d = count_q + (abits+1)'(1);
      else if (!wr_ok && rd_ok) count_d = count_q - (abits+1)'(1);
    end

    if (drop)                overrun_d = 1'b1;
    else if (bus_if.clr_err) overrun_d = 1'b0;

    // Counter stops at the limit; the detector fires on the tick that reaches it.
    if (!run) begin
      tmr_d   = '0;
      armed_d = 1'b0;
    end else if (bus_if.rx_done) begin
      tmr_d   = '0;
      armed_d = 1'b1;
    end else if (bus_if.tick && tmr_q != tc_last) begin
      tmr_d = tmr_q + tbits'(1);
      if (tmr_q == tc_fire) begin
        idle_d  = armed_q & ~is_empty;
        armed_d = 1'b0;
      end
    end
  end

  assign bus_if.rx_rst       = ~run;
  assign bus_if.rd_data      = mem[rd_ptr_q];
  assign bus_if.empty        = is_empty;
  assign bus_if.full         = is_full;
  assign bus_if.count        = count_q;
  assign bus_if.overrun      = overrun_q;
  assign bus_if.idle_timeout = idle_q;
endmodule
